neo_frame_sequencer: RTL and testbench

//  Frame-level controller for the NEO datapath. On start it streams a frame of

---
 rtl/neo_frame_sequencer_if.sv | 49 ++++
 rtl/neo_frame_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_neo_frame_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neo_frame_sequencer_if.sv
// Purpose: frame request, sample-RAM read port, result-RAM write port and frame statistics of the NEO sequencer.
// Latency: pure wiring bundle, no storage.
// Backpressure: none; the RAM ports are fixed-timing and start is only accepted while the sequencer is idle.
interface neo_frame_sequencer_if #(
  parameter int N  = 16,
  parameter int M  = 16,
  parameter int AW = $clog2(M) + 1
) ();

  // frame request
  logic                start;
  logic [AW-1:0]       frame_len;
  logic signed [N-1:0] threshold;

  // status
  logic                busy;
  logic                done;
  logic                err;

  // sample RAM read port (data returns one cycle after ren/raddr)
  logic                ren;
  logic [AW-1:0]       raddr;
  logic signed [N-1:0] rdata;

  // result RAM write port
  logic                wen;
  logic [AW-1:0]       waddr;
  logic signed [N-1:0] wdata;

  // statistics of the last frame
  logic [AW-1:0]       spike_count;
  logic signed [N-1:0] peak;
  logic [AW-1:0]       peak_idx;

  // requester / RAM side
  modport master (
    output start, frame_len, threshold, rdata,
    input  busy, done, err, ren, raddr, wen, waddr, wdata,
    input  spike_count, peak, peak_idx
  );

  // sequencer side
  modport slave (
    input  start, frame_len, threshold, rdata,
    output busy, done, err, ren, raddr, wen, waddr, wdata,
    output spike_count, peak, peak_idx
  );

endinterface

// File: rtl/neo_frame_sequencer.sv
// Purpose: streams one frame out of the sample RAM, writes saturated psi[n] = x[n]^2 - x[n+1]*x[n-1] to the result RAM, keeps spike/peak statistics.
// Latency: first result write 5 cycles after the start edge, done pulse L+3 cycles after it.
// Backpressure: none; RAM ports run at fixed timing and start is ignored (not queued) while busy or in DONE.
module neo_frame_sequencer #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int SHIFT = 15
) (
  input  logic                  Clk,
  input  logic                  reset,
  neo_frame_sequencer_if.slave  bus
);

  localparam int AW = $clog2(M) + 1;

  // Saturation bounds expressed at the width of the shifted difference.
  localparam logic signed [2*N:0]  SAT_HI  = (2*N+1)'((2**(N-1)) - 1);
  localparam logic signed [2*N:0]  SAT_LO  = (2*N+1)'(-(2**(N-1)));
  localparam logic signed [N-1:0]  PSI_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // FSM decoded outputs
  logic busy_c;
  logic done_c;
  logic ren_c;

  // frame control
  logic                len_ok;
  logic                accept;
  logic [AW-1:0]       len_q;
  logic [AW-1:0]       cnt_q;
  logic                drain_q;
  logic signed [N-1:0] thr_q;

  // read-return tracking and sample pipeline
  logic                rd_vld_q;
  logic [AW-1:0]       rd_idx_q;
  logic signed [N-1:0] xc_q;
  logic signed [N-1:0] xp_q;

  // psi arithmetic
  logic signed [2*N-1:0] sq;
  logic signed [2*N-1:0] pr;
  logic signed [2*N:0]   diff;
  logic signed [2*N:0]   shf;
  logic signed [N-1:0]   psi_sat;
  logic                  wr_go;
  logic [AW-1:0]         wr_idx;

  // result write port registers
  logic                wen_q;
  logic [AW-1:0]       waddr_q;
  logic signed [N-1:0] wdata_q;

  // statistics registers
  logic [AW-1:0]       spike_q;
  logic signed [N-1:0] peak_q;
  logic [AW-1:0]       pidx_q;
  logic                err_q;

  assign len_ok = (bus.frame_len >= AW'(3)) && (bus.frame_len <= AW'(M));
  assign accept = (state == IDLE) && bus.start;

  // State register; reset abandons any frame in flight.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    ren_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = len_ok ? RUN : DONE;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        ren_c  = 1'b1;
        if (cnt_q == len_q - AW'(1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (drain_q) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch frame parameters on accept; walk the read address through RUN; time the two drain cycles.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      len_q   <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      if (accept) begin
        len_q <= bus.frame_len;
        thr_q <= bus.threshold;
        cnt_q <= '0;
      end else if (state == RUN) begin
        cnt_q <= cnt_q + AW'(1);
      end
      drain_q <= (state == DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // Track which sample index the RAM is returning and shift it into the two-deep pipeline.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      xc_q     <= '0;
      xp_q     <= '0;
    end else begin
      rd_vld_q <= ren_c;
      if (ren_c) begin
        rd_idx_q <= cnt_q;
      end
      if (rd_vld_q) begin
        xc_q <= bus.rdata;
        xp_q <= xc_q;
      end
    end
  end

  // psi for the centre sample xc, using the sample before (xp) and the one arriving now (rdata).
  always_comb begin
    sq      = (2*N)'(xc_q) * (2*N)'(xc_q);
    pr      = (2*N)'(bus.rdata) * (2*N)'(xp_q);
    diff    = (2*N+1)'(sq) - (2*N+1)'(pr);
    shf     = diff >>> SHIFT;
    psi_sat = shf[N-1:0];
    if (shf > SAT_HI) begin
      psi_sat = SAT_HI[N-1:0];
    end else if (shf < SAT_LO) begin
      psi_sat = SAT_LO[N-1:0];
    end
  end

  // A result exists once the third sample of the frame is on rdata; it belongs to the previous index.
  assign wr_go  = rd_vld_q && (rd_idx_q >= AW'(2));
  assign wr_idx = rd_idx_q - AW'(1);

  // Register the result RAM write.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= wr_go;
      if (wr_go) begin
        waddr_q <= wr_idx;
        wdata_q <= psi_sat;
      end
    end
  end

  // Statistics: cleared on accept, updated alongside each write so they are current whenever wen is seen.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      spike_q <= '0;
      peak_q  <= '0;
      pidx_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      spike_q <= '0;
      peak_q  <= PSI_MIN;
      pidx_q  <= '0;
      err_q   <= ~len_ok;
    end else if (wr_go) begin
      if (psi_sat > thr_q) begin
        spike_q <= spike_q + AW'(1);
      end
      // strict compare keeps the lowest index on ties
      if (psi_sat > peak_q) begin
        peak_q <= psi_sat;
        pidx_q <= wr_idx;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.err         = err_q;
  assign bus.ren         = ren_c;
  assign bus.raddr       = ren_c ? cnt_q : '0;
  assign bus.wen         = wen_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.spike_count = spike_q;
  assign bus.peak        = peak_q;
  assign bus.peak_idx    = pidx_q;

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Purpose: directed frames against neo_frame_sequencer with hand-computed psi values, timing and statistics.
// Latency: checks done at start+L+3 and first write at start+5.
// Backpressure: the sample RAM model answers every read one cycle later.
module tb_neo_frame_sequencer;

  localparam int N     = 16;
  localparam int M     = 16;
  localparam int SHIFT = 15;
  localparam int AW    = $clog2(M) + 1;

  logic Clk   = 1'b0;
  logic reset = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic signed [N-1:0] mem [0:(1<<AW)-1];
  int ex [0:31];

  // per-frame observations
  int done_cyc, ren_n, ren_bad, busy_n, nw, first_w, last_w, err_k1;
  int sc, pk, pi, er, post_done, post_busy, post_err, after_rw;
  int w_addr [0:31];
  int w_data [0:31];
  int n_done;

  neo_frame_sequencer_if #(.N(N), .M(M)) bus ();

  neo_frame_sequencer #(.N(N), .M(M), .SHIFT(SHIFT)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // sample RAM: registered read
  always @(posedge Clk) bus.rdata <= bus.ren ? mem[bus.raddr] : '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  endtask

  task automatic rst_checks(input string t);
    chk({t, ".busy"},  int'(bus.busy), 0);
    chk({t, ".done"},  int'(bus.done), 0);
    chk({t, ".err"},   int'(bus.err), 0);
    chk({t, ".ren"},   int'(bus.ren), 0);
    chk({t, ".raddr"}, int'(bus.raddr), 0);
    chk({t, ".wen"},   int'(bus.wen), 0);
    chk({t, ".waddr"}, int'(bus.waddr), 0);
    chk({t, ".wdata"}, int'(bus.wdata), 0);
    chk({t, ".spike"}, int'(bus.spike_count), 0);
    chk({t, ".peak"},  int'(bus.peak), 0);
    chk({t, ".pidx"},  int'(bus.peak_idx), 0);
  endtask

  // Request one frame, then change frame_len/threshold so late changes would show.
  // Optionally pulse start again while the frame is running.
  task automatic run_frame(input int len, input int thr, input bit poke);
    done_cyc = -1; ren_n = 0; ren_bad = 0; busy_n = 0; nw = 0;
    first_w = -1; last_w = -1; err_k1 = -1; after_rw = 0;
    sc = -1; pk = -1; pi = -1; er = -1;
    @(negedge Clk);
    bus.frame_len = AW'(len);
    bus.threshold = N'(thr);
    bus.start     = 1'b1;
    @(posedge Clk);
    #1;
    bus.start     = 1'b0;
    bus.frame_len = AW'(3);
    bus.threshold = 16'sh7fff;
    for (int k = 1; k <= 60 && done_cyc < 0; k++) begin
      @(negedge Clk);
      if (k == 1) err_k1 = int'(bus.err);
      if (bus.busy) busy_n++;
      if (bus.ren) begin
        if (int'(bus.raddr) != ren_n || k != ren_n + 1) ren_bad++;
        ren_n++;
      end
      if (bus.wen) begin
        if (nw == 0) first_w = k;
        last_w = k;
        if (nw < 32) begin
          w_addr[nw] = int'(bus.waddr);
          w_data[nw] = int'(bus.wdata);
        end
        nw++;
      end
      if (bus.done) begin
        done_cyc = k;
        sc = int'(bus.spike_count);
        pk = int'(bus.peak);
        pi = int'(bus.peak_idx);
        er = int'(bus.err);
      end
      bus.start = poke && (k == 2);
    end
    bus.start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      if (j == 0) begin
        post_done = int'(bus.done);
        post_busy = int'(bus.busy);
        post_err  = int'(bus.err);
      end
      if (bus.ren || bus.wen) after_rw++;
    end
  endtask

  task automatic check_frame(input string t, input int len, input int e_cnt, input int e_peak, input int e_idx);
    chk({t, ".done_cyc"}, done_cyc, len + 3);
    chk({t, ".ren_cycles"}, ren_n, len);
    chk({t, ".raddr_seq_errs"}, ren_bad, 0);
    chk({t, ".busy_cycles"}, busy_n, len + 2);
    chk({t, ".n_writes"}, nw, len - 2);
    chk({t, ".first_wr_cyc"}, first_w, 5);
    chk({t, ".last_wr_cyc"}, last_w, len + 2);
    for (int i = 0; i < nw && i < len - 2; i++) begin
      chk($sformatf("%s.waddr%0d", t, i), w_addr[i], i + 1);
      chk($sformatf("%s.psi%0d", t, i + 1), w_data[i], ex[i + 1]);
    end
    chk({t, ".spike_count"}, sc, e_cnt);
    chk({t, ".peak"}, pk, e_peak);
    chk({t, ".peak_idx"}, pi, e_idx);
    chk({t, ".err_at_done"}, er, 0);
    chk({t, ".err_after_accept"}, err_k1, 0);
    chk({t, ".done_pulse_len"}, post_done, 0);
    chk({t, ".busy_after_done"}, post_busy, 0);
    chk({t, ".ram_after_done"}, after_rw, 0);
  endtask

  task automatic check_bad(input string t);
    chk({t, ".done_cyc"}, done_cyc, 1);
    chk({t, ".ren_cycles"}, ren_n, 0);
    chk({t, ".n_writes"}, nw, 0);
    chk({t, ".busy_cycles"}, busy_n, 0);
    chk({t, ".err_at_done"}, er, 1);
    chk({t, ".err_held"}, post_err, 1);
    chk({t, ".done_pulse_len"}, post_done, 0);
    chk({t, ".ram_after_done"}, after_rw, 0);
  endtask

  task automatic load_t1();
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'sd1000;
    for (int i = 1; i <= 6; i++) ex[i] = 0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.threshold = '0;
    clear_mem();

    // reset state
    reset = 1'b0;
    repeat (2) @(negedge Clk);
    rst_checks("reset");
    reset = 1'b1;
    repeat (2) @(negedge Clk);

    // 1: constant samples -> all psi zero, first write holds the peak
    load_t1();
    run_frame(8, 0, 1'b0);
    check_frame("t1_const", 8, 0, 0, 1);

    // 2: ramp 1000*n -> psi = 10^6 >>> 15 = 30 everywhere; start pulsed mid-frame is ignored
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = N'(1000 * i);
    for (int i = 1; i <= 6; i++) ex[i] = 30;
    run_frame(8, 29, 1'b1);
    check_frame("t2_ramp", 8, 6, 30, 1);

    // 3: single impulse 16384 at n=4 -> psi[4] = 2^28 >>> 15 = 8192
    clear_mem();
    mem[4] = 16'sd16384;
    for (int i = 1; i <= 6; i++) ex[i] = 0;
    ex[4] = 8192;
    run_frame(8, 100, 1'b0);
    check_frame("t3_impulse", 8, 1, 8192, 4);

    // 4: extremes, L=5: psi[2] = 2^30>>>15 = 32768 -> 32767; psi[3] = -65535>>>15 = -2
    clear_mem();
    mem[2] = -16'sd32768;
    mem[3] = 16'sd32767;
    mem[4] = -16'sd32768;
    ex[1] = 0; ex[2] = 32767; ex[3] = -2;
    run_frame(5, 0, 1'b0);
    check_frame("t4_sat", 5, 1, 32767, 2);

    // 5: out-of-range lengths, then a minimal valid frame clears err
    run_frame(2, 0, 1'b0);
    check_bad("t5_len2");
    run_frame(17, 0, 1'b0);
    check_bad("t5_len17");
    // L=3: psi[1] = 9e6 - 10e6 = -1e6 >>> 15 = -31, strict compare against -32
    clear_mem();
    mem[0] = 16'sd2000; mem[1] = 16'sd3000; mem[2] = 16'sd5000;
    ex[1] = -31;
    run_frame(3, -32, 1'b0);
    check_frame("t5_len3", 3, 1, -31, 1);

    // 7: -2^30 >>> 15 = -32768 exactly (no clamp); threshold at minimum, compare is strict
    clear_mem();
    mem[0] = -16'sd32768; mem[2] = -16'sd32768;
    ex[1] = -32768; ex[2] = 32767;
    run_frame(4, -32768, 1'b0);
    check_frame("t7_negmin", 4, 1, 32767, 2);

    // 6: reset sampled at S+4 abandons the frame with no done pulse
    load_t1();
    @(negedge Clk);
    bus.frame_len = AW'(8);
    bus.threshold = '0;
    bus.start     = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("t6.peak_init", int'(bus.peak), -32768);
    chk("t6.busy_mid", int'(bus.busy), 1);
    reset = 1'b0;
    @(negedge Clk);
    rst_checks("t6_midreset");
    reset = 1'b1;
    n_done = 0;
    repeat (20) begin
      @(negedge Clk);
      if (bus.done || bus.busy || bus.ren || bus.wen) n_done++;
    end
    chk("t6.no_activity_after_reset", n_done, 0);
    run_frame(8, 0, 1'b0);
    check_frame("t6_rerun", 8, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
